// File: rtl/core_pkg.sv
// Shared types and sizing for the 9-bit accumulator core (sequencer, decoder, ROM, data memory).
package core_pkg;

  localparam int unsigned PC_W            = 10;
  localparam int unsigned LUT_AW          = 6;
  localparam int unsigned MEM_LAT_DEFAULT = 2;
  localparam int unsigned JPTR_W          = 8;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    RUN       = 2'd1,
    LOAD_WAIT = 2'd2,
    HALT      = 2'd3
  } seq_state_t;

endpackage : core_pkg

// File: rtl/jump_lut.sv
// Jump-target table: absolute branch targets, one synchronous write port, one asynchronous read port.
module jump_lut #(
  parameter int unsigned LUT_AW = 6,
  parameter int unsigned PC_W   = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [LUT_AW-1:0] waddr,
  input  logic [PC_W-1:0]   wdata,
  input  logic [LUT_AW-1:0] raddr,
  output logic [PC_W-1:0]   rdata
);

  localparam int unsigned DEPTH = 2 ** LUT_AW;

  logic [PC_W-1:0] mem [DEPTH];

  // Configuration write; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // A same-cycle write is not visible here until the following cycle.
  assign rdata = mem[raddr];

endmodule : jump_lut

// File: rtl/fetch_sequencer.sv
// Program sequencer: owns the PC, the Start/Done run handshake, branch resolution and load stalls.
module fetch_sequencer #(
  parameter int unsigned PC_W    = core_pkg::PC_W,
  parameter int unsigned LUT_AW  = core_pkg::LUT_AW,
  parameter int unsigned MEM_LAT = core_pkg::MEM_LAT_DEFAULT
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic              DoneIn,
  input  logic              RenD,
  input  logic              Jen,
  input  logic [7:0]        Jptr,
  input  logic              BrCond,
  input  logic              Lut_we,
  input  logic [LUT_AW-1:0] Lut_waddr,
  input  logic [PC_W-1:0]   Lut_wdata,
  output logic [PC_W-1:0]   Prog_ctr,
  output logic              Commit,
  output logic              Stall,
  output logic              Busy,
  output logic              Done
);

  import core_pkg::*;

  // Counter holds the remaining stall cycles after the first one (MEM_LAT-2 at most).
  localparam int unsigned CNT_W = (MEM_LAT > 2) ? $clog2(MEM_LAT - 1) : 1;

  seq_state_t       state_q, state_d;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [PC_W-1:0]  lut_rdata;
  logic             unused_jptr_hi;

  // Only the low LUT_AW bits of the jump pointer select an entry.
  assign unused_jptr_hi = ^Jptr[7:LUT_AW];

  jump_lut #(
    .LUT_AW (LUT_AW),
    .PC_W   (PC_W)
  ) u_jump_lut (
    .clk   (Clk),
    .we    (Lut_we),
    .waddr (Lut_waddr),
    .wdata (Lut_wdata),
    .raddr (Jptr[LUT_AW-1:0]),
    .rdata (lut_rdata)
  );

  // State, PC, status flags and wait counter; reset is synchronous.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= IDLE;
      pc_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state, next-PC and the combinational Commit/Stall qualifiers.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    busy_d  = busy_q;
    done_d  = done_q;
    cnt_d   = cnt_q;
    Commit  = 1'b0;
    Stall   = 1'b0;

    case (state_q)
      IDLE: begin
        if (Start) begin
          state_d = RUN;
          pc_d    = '0;
          busy_d  = 1'b1;
        end
      end

      RUN: begin
        if (DoneIn) begin
          state_d = HALT;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else if (RenD && (MEM_LAT > 1)) begin
          state_d = LOAD_WAIT;
          cnt_d   = CNT_W'(MEM_LAT - 2);
          Stall   = 1'b1;
        end else if (Jen && BrCond) begin
          pc_d   = lut_rdata;
          Commit = 1'b1;
        end else begin
          pc_d   = pc_q + PC_W'(1);
          Commit = 1'b1;
        end
      end

      LOAD_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CNT_W'(1);
          Stall = 1'b1;
        end else begin
          state_d = RUN;
          pc_d    = pc_q + PC_W'(1);
          Commit  = 1'b1;
        end
      end

      HALT: begin
        if (Start) begin
          state_d = RUN;
          pc_d    = '0;
          busy_d  = 1'b1;
          done_d  = 1'b0;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign Prog_ctr = pc_q;
  assign Busy     = busy_q;
  assign Done     = done_q;

endmodule : fetch_sequencer

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus a randomized run against a cycle model.
module tb_fetch_sequencer;

  localparam int unsigned PC_W    = 10;
  localparam int unsigned LUT_AW  = 6;
  localparam int unsigned MEM_LAT = 3;

  logic              Clk = 1'b0;
  logic              Reset, Start, DoneIn, RenD, Jen, BrCond, Lut_we;
  logic [7:0]        Jptr;
  logic [LUT_AW-1:0] Lut_waddr;
  logic [PC_W-1:0]   Lut_wdata;
  logic [PC_W-1:0]   Prog_ctr;
  logic              Commit, Stall, Busy, Done;

  int total = 0;
  int bad   = 0;

  // Behavioural model: program counter, run/halt flags, and stall cycles left in a load.
  logic [PC_W-1:0] m_pc = '0;
  bit              m_busy = 0, m_done = 0, m_loading = 0;
  int              m_left = 0;
  logic [PC_W-1:0] m_lut [64];
  bit              exp_commit, exp_stall;
  logic            obs_commit, obs_stall;

  fetch_sequencer #(
    .PC_W    (PC_W),
    .LUT_AW  (LUT_AW),
    .MEM_LAT (MEM_LAT)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Start     (Start),
    .DoneIn    (DoneIn),
    .RenD      (RenD),
    .Jen       (Jen),
    .Jptr      (Jptr),
    .BrCond    (BrCond),
    .Lut_we    (Lut_we),
    .Lut_waddr (Lut_waddr),
    .Lut_wdata (Lut_wdata),
    .Prog_ctr  (Prog_ctr),
    .Commit    (Commit),
    .Stall     (Stall),
    .Busy      (Busy),
    .Done      (Done)
  );

  always #5 Clk = ~Clk;

  task automatic quiet();
    Reset = 1'b1; Start = 1'b0; DoneIn = 1'b0; RenD = 1'b0; Jen = 1'b0;
    BrCond = 1'b0; Jptr = 8'h00; Lut_we = 1'b0; Lut_waddr = '0; Lut_wdata = '0;
  endtask

  // One clock: sample Commit/Stall, predict the edge from the rules, advance, settle.
  task automatic tick();
    logic [PC_W-1:0] n_pc;
    bit n_busy, n_done, n_loading;
    int n_left;
    #1;
    obs_commit = Commit;
    obs_stall  = Stall;
    exp_commit = 0; exp_stall = 0;
    n_pc = m_pc; n_busy = m_busy; n_done = m_done; n_loading = m_loading; n_left = m_left;
    if (!m_busy) begin
      if (Start) begin n_pc = '0; n_busy = 1; n_done = 0; end
    end else if (m_loading) begin
      if (m_left == 1) begin exp_commit = 1; n_pc = m_pc + 1'b1; n_loading = 0; end
      else begin exp_stall = 1; n_left = m_left - 1; end
    end else if (DoneIn) begin
      n_busy = 0; n_done = 1;
    end else if (RenD && MEM_LAT > 1) begin
      exp_stall = 1; n_loading = 1; n_left = MEM_LAT - 1;
    end else if (Jen && BrCond) begin
      exp_commit = 1; n_pc = m_lut[Jptr[5:0]];
    end else begin
      exp_commit = 1; n_pc = m_pc + 1'b1;
    end
    if (Lut_we) m_lut[Lut_waddr] = Lut_wdata;
    if (!Reset) begin n_pc = '0; n_busy = 0; n_done = 0; n_loading = 0; n_left = 0; end
    @(posedge Clk);
    #1;
    m_pc = n_pc; m_busy = n_busy; m_done = n_done; m_loading = n_loading; m_left = n_left;
  endtask

  task automatic test_reset();
    quiet();
    Reset = 1'b0; tick(); tick();
    Reset = 1'b1; tick();
    total++; if (Prog_ctr !== 10'h000) begin bad++; $display("FAIL reset_pc: got %h want 000", Prog_ctr); end
    total++; if (Busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", Busy); end
    total++; if (Done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", Done); end
    total++; if (Commit !== 1'b0 || Stall !== 1'b0) begin bad++; $display("FAIL reset_comb: commit %b stall %b want 0 0", Commit, Stall); end
    tick();
    total++; if (Prog_ctr !== 10'h000 || Busy !== 1'b0) begin bad++; $display("FAIL reset_idle_hold: pc %h busy %b want 000 0", Prog_ctr, Busy); end
    // Fill the jump table so every later branch has a known target.
    for (int i = 0; i < 64; i++) begin
      Lut_we = 1'b1; Lut_waddr = LUT_AW'(i); Lut_wdata = PC_W'($urandom);
      tick();
    end
    quiet();
  endtask

  task automatic test_straight();
    quiet();
    Start = 1'b1; tick(); Start = 1'b0;
    total++; if (Prog_ctr !== 10'h000 || Busy !== 1'b1) begin bad++; $display("FAIL start_pc: pc %h busy %b want 000 1", Prog_ctr, Busy); end
    for (int i = 1; i <= 3; i++) begin
      tick();
      total++; if (Prog_ctr !== PC_W'(i)) begin bad++; $display("FAIL straight_pc: got %h want %h", Prog_ctr, PC_W'(i)); end
      total++; if (obs_commit !== 1'b1) begin bad++; $display("FAIL straight_commit: got %b want 1", obs_commit); end
    end
    DoneIn = 1'b1; tick(); DoneIn = 1'b0;
    total++; if (obs_commit !== 1'b0) begin bad++; $display("FAIL done_commit: got %b want 0", obs_commit); end
    total++; if (Done !== 1'b1 || Busy !== 1'b0 || Prog_ctr !== 10'h003) begin bad++; $display("FAIL halt: done %b busy %b pc %h want 1 0 003", Done, Busy, Prog_ctr); end
    tick();
    total++; if (Done !== 1'b1 || Prog_ctr !== 10'h003) begin bad++; $display("FAIL halt_hold: done %b pc %h want 1 003", Done, Prog_ctr); end
  endtask

  task automatic test_branch();
    quiet();
    Lut_we = 1'b1; Lut_waddr = 6'd5; Lut_wdata = 10'h120; tick(); quiet();
    for (int pass = 0; pass < 3; pass++) begin
      if (pass != 0) begin DoneIn = 1'b1; tick(); DoneIn = 1'b0; end
      Start = 1'b1; tick(); Start = 1'b0;
      for (int i = 0; i < 7; i++) tick();
      total++; if (Prog_ctr !== 10'h007) begin bad++; $display("FAIL branch_setup: got %h want 007", Prog_ctr); end
      Jen = 1'b1;
      Jptr   = (pass == 2) ? 8'hC5 : 8'h05;
      BrCond = (pass != 1);
      tick(); quiet();
      total++; if (Prog_ctr !== ((pass == 1) ? 10'h008 : 10'h120)) begin bad++; $display("FAIL branch_target[%0d]: got %h want %h", pass, Prog_ctr, (pass == 1) ? 10'h008 : 10'h120); end
      total++; if (obs_commit !== 1'b1) begin bad++; $display("FAIL branch_commit[%0d]: got %b want 1", pass, obs_commit); end
    end
  endtask

  task automatic test_load();
    logic [2:0] exp_st, exp_cm;
    quiet();
    DoneIn = 1'b1; tick(); DoneIn = 1'b0;
    Start = 1'b1; tick(); Start = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    total++; if (Prog_ctr !== 10'h004) begin bad++; $display("FAIL load_setup: got %h want 004", Prog_ctr); end
    exp_st = 3'b110; exp_cm = 3'b001;
    for (int i = 0; i < 3; i++) begin
      RenD = (i == 0); tick();
      total++; if (obs_stall !== exp_st[2-i] || obs_commit !== exp_cm[2-i]) begin bad++; $display("FAIL load_cycle%0d: stall %b commit %b want %b %b", i, obs_stall, obs_commit, exp_st[2-i], exp_cm[2-i]); end
      total++; if (Prog_ctr !== ((i == 2) ? 10'h005 : 10'h004)) begin bad++; $display("FAIL load_pc%0d: got %h", i, Prog_ctr); end
    end
    RenD = 1'b1; tick(); RenD = 1'b0;
    Reset = 1'b0; tick(); Reset = 1'b1;
    total++; if (obs_stall !== 1'b1) begin bad++; $display("FAIL load_abort_stall: got %b want 1", obs_stall); end
    total++; if (Prog_ctr !== 10'h000 || Busy !== 1'b0 || Done !== 1'b0) begin bad++; $display("FAIL load_abort: pc %h busy %b done %b want 000 0 0", Prog_ctr, Busy, Done); end
    tick();
    total++; if (obs_commit !== 1'b0 || obs_stall !== 1'b0 || Prog_ctr !== 10'h000) begin bad++; $display("FAIL after_abort_idle: commit %b stall %b pc %h", obs_commit, obs_stall, Prog_ctr); end
  endtask

  task automatic test_lut_collision();
    quiet();
    Start = 1'b1; tick(); Start = 1'b0;
    Lut_we = 1'b1; Lut_waddr = 6'd2; Lut_wdata = 10'h010; tick(); quiet();
    Jen = 1'b1; BrCond = 1'b1; Jptr = 8'h02;
    Lut_we = 1'b1; Lut_waddr = 6'd2; Lut_wdata = 10'h040;
    tick(); quiet();
    total++; if (Prog_ctr !== 10'h010) begin bad++; $display("FAIL lut_old_value: got %h want 010", Prog_ctr); end
    Jen = 1'b1; BrCond = 1'b1; Jptr = 8'h02; tick(); quiet();
    total++; if (Prog_ctr !== 10'h040) begin bad++; $display("FAIL lut_new_value: got %h want 040", Prog_ctr); end
  endtask

  task automatic test_wrap_and_start();
    quiet();
    Lut_we = 1'b1; Lut_waddr = 6'd9; Lut_wdata = 10'h3FF; tick(); quiet();
    Jen = 1'b1; BrCond = 1'b1; Jptr = 8'h09; tick(); quiet();
    total++; if (Prog_ctr !== 10'h3FF) begin bad++; $display("FAIL wrap_setup: got %h want 3ff", Prog_ctr); end
    tick();
    total++; if (Prog_ctr !== 10'h000) begin bad++; $display("FAIL wrap: got %h want 000", Prog_ctr); end
    Start = 1'b1; tick(); Start = 1'b0;
    total++; if (Prog_ctr !== 10'h001 || Busy !== 1'b1) begin bad++; $display("FAIL start_in_run: pc %h busy %b want 001 1", Prog_ctr, Busy); end
    DoneIn = 1'b1; tick(); DoneIn = 1'b0;
    Start = 1'b1; tick(); Start = 1'b0;
    total++; if (Prog_ctr !== 10'h000 || Done !== 1'b0 || Busy !== 1'b1) begin bad++; $display("FAIL restart: pc %h done %b busy %b want 000 0 1", Prog_ctr, Done, Busy); end
  endtask

  task automatic test_random();
    quiet();
    for (int n = 0; n < 1500; n++) begin
      Reset     = ($urandom_range(199) != 0);
      Start     = ($urandom_range(7) == 0);
      DoneIn    = ($urandom_range(15) == 0);
      RenD      = ($urandom_range(3) == 0);
      Jen       = ($urandom_range(2) == 0);
      BrCond    = 1'($urandom);
      Jptr      = 8'($urandom);
      Lut_we    = ($urandom_range(5) == 0);
      Lut_waddr = LUT_AW'($urandom);
      Lut_wdata = PC_W'($urandom);
      tick();
      total++; if (obs_commit !== exp_commit || obs_stall !== exp_stall) begin bad++; $display("FAIL rnd_comb@%0d: commit %b stall %b want %b %b", n, obs_commit, obs_stall, exp_commit, exp_stall); end
      total++; if (Prog_ctr !== m_pc) begin bad++; $display("FAIL rnd_pc@%0d: got %h want %h", n, Prog_ctr, m_pc); end
      total++; if (Busy !== m_busy || Done !== m_done) begin bad++; $display("FAIL rnd_flags@%0d: busy %b done %b want %b %b", n, Busy, Done, m_busy, m_done); end
    end
    quiet();
  endtask

  initial begin
    quiet();
    @(posedge Clk); #1;
    test_reset();
    test_straight();
    test_branch();
    test_load();
    test_lut_collision();
    test_wrap_and_start();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_fetch_sequencer
